// File: rtl/booth_mac_accumulator_pkg.sv
// Shared types, default widths and saturation limits for the Booth MAC accumulator.
// Saturation limits are only consumed when MAC_SATURATE_EN is defined.
package booth_mac_accumulator_pkg;

  localparam int PROD_W_DEF = 8;
  localparam int ACC_W_DEF  = 16;
  localparam int CNT_W_DEF  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Limits are returned 64 bits wide; callers keep the low w bits.
  function automatic logic [63:0] sat_max(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_min(input int w);
    return ~sat_max(w);
  endfunction

endpackage

// File: rtl/booth_mac_accumulator_if.sv
// Product-in / result-out handshake bundle between the Booth multiplier and the MAC accumulator.
interface booth_mac_accumulator_if
  import booth_mac_accumulator_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
);

  logic                     ena;
  logic                     start_i;
  logic        [CNT_W-1:0]  len_i;
  logic signed [PROD_W-1:0] prod_i;
  logic                     prod_valid_i;
  logic                     prod_ready_o;
  logic signed [ACC_W-1:0]  acc_o;
  logic                     acc_valid_o;
  logic                     acc_ready_i;
  logic                     ovf_o;
  logic                     busy_o;

  modport slave (
    input  ena, start_i, len_i, prod_i, prod_valid_i, acc_ready_i,
    output prod_ready_o, acc_o, acc_valid_o, ovf_o, busy_o
  );

  modport master (
    output ena, start_i, len_i, prod_i, prod_valid_i, acc_ready_i,
    input  prod_ready_o, acc_o, acc_valid_o, ovf_o, busy_o
  );

endinterface

// File: rtl/booth_mac_accumulator_adder.sv
// Combinational sign-extending adder with signed overflow detect.
// Config macro MAC_SATURATE_EN: clamp to the signed limits on overflow instead of wrapping.
module booth_mac_accumulator_adder
  import booth_mac_accumulator_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic signed [ACC_W-1:0]  acc,
  input  logic signed [PROD_W-1:0] prod,
  output logic signed [ACC_W-1:0]  sum,
  output logic                     ovf
);

`ifdef MAC_SATURATE_EN
  localparam logic [63:0]      SAT_MAX_FULL = sat_max(ACC_W);
  localparam logic [63:0]      SAT_MIN_FULL = sat_min(ACC_W);
  localparam logic [ACC_W-1:0] SAT_MAX      = SAT_MAX_FULL[ACC_W-1:0];
  localparam logic [ACC_W-1:0] SAT_MIN      = SAT_MIN_FULL[ACC_W-1:0];
`endif

  logic [ACC_W:0] acc_ext;
  logic [ACC_W:0] prod_ext;
  logic [ACC_W:0] sum_ext;

  always_comb begin
    acc_ext  = {acc[ACC_W-1], acc};
    prod_ext = {{(ACC_W + 1 - PROD_W){prod[PROD_W-1]}}, prod};
    sum_ext  = acc_ext + prod_ext;
    ovf      = sum_ext[ACC_W] ^ sum_ext[ACC_W-1];
`ifdef MAC_SATURATE_EN
    // Bit ACC_W of the extended sum is the sign of the true result.
    if (ovf) begin
      sum = sum_ext[ACC_W] ? SAT_MIN : SAT_MAX;
    end else begin
      sum = sum_ext[ACC_W-1:0];
    end
`else
    sum = sum_ext[ACC_W-1:0];
`endif
  end

endmodule

// File: rtl/booth_mac_accumulator.sv
// Block MAC: sums len_i signed products into a wide accumulator and holds the result until taken.
// Config macro MAC_SATURATE_EN (see booth_mac_accumulator_adder) selects saturating arithmetic.
module booth_mac_accumulator
  import booth_mac_accumulator_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  booth_mac_accumulator_if.slave bus
);

  localparam logic [CNT_W:0] FULL_LEN = {1'b1, {CNT_W{1'b0}}};
  localparam logic [CNT_W:0] ONE      = {{CNT_W{1'b0}}, 1'b1};

  state_t                  state, state_nxt;
  logic signed [ACC_W-1:0] acc, acc_nxt;
  logic        [CNT_W:0]   remaining, remaining_nxt;
  logic                    ovf, ovf_nxt;

  logic signed [ACC_W-1:0] add_sum;
  logic                    add_ovf;
  logic                    prod_take;

  booth_mac_accumulator_adder #(
    .PROD_W (PROD_W),
    .ACC_W  (ACC_W)
  ) u_adder (
    .acc  (acc),
    .prod (bus.prod_i),
    .sum  (add_sum),
    .ovf  (add_ovf)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      remaining <= '0;
      ovf       <= 1'b0;
    end else begin
      state     <= state_nxt;
      acc       <= acc_nxt;
      remaining <= remaining_nxt;
      ovf       <= ovf_nxt;
    end
  end

  // Every transition is qualified by ena, so ena=0 freezes all state.
  always_comb begin
    state_nxt     = state;
    acc_nxt       = acc;
    remaining_nxt = remaining;
    ovf_nxt       = ovf;
    prod_take     = (state == ACCUM) && bus.ena && bus.prod_valid_i;

    case (state)
      IDLE: begin
        if (bus.ena && bus.start_i) begin
          acc_nxt       = '0;
          ovf_nxt       = 1'b0;
          remaining_nxt = (bus.len_i == '0) ? FULL_LEN : {1'b0, bus.len_i};
          state_nxt     = ACCUM;
        end
      end
      ACCUM: begin
        if (prod_take) begin
          acc_nxt       = add_sum;
          ovf_nxt       = ovf | add_ovf;
          remaining_nxt = remaining - ONE;
          if (remaining == ONE) begin
            state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        if (bus.ena && bus.acc_ready_i) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign bus.prod_ready_o = (state == ACCUM) && bus.ena;
  assign bus.acc_valid_o  = (state == HOLD);
  assign bus.busy_o       = (state == ACCUM) || (state == HOLD);
  assign bus.acc_o        = acc;
  assign bus.ovf_o        = ovf;

endmodule
